// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and buffered mul/div results
// into the register file write port, and tracks pending long-latency destinations.
module wb_arbiter #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned FIFO_DEPTH     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alu_wr_en_i,
    input  logic [REG_ADDR_WIDTH-1:0] alu_wr_addr_i,
    input  logic [DATA_WIDTH-1:0]     alu_wr_data_i,
    input  logic                      md_valid_i,
    output logic                      md_ready_o,
    input  logic [REG_ADDR_WIDTH-1:0] md_wr_addr_i,
    input  logic [DATA_WIDTH-1:0]     md_wr_data_i,
    input  logic                      issue_en_i,
    input  logic [REG_ADDR_WIDTH-1:0] issue_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
    input  logic                      dec_rd_en_i,
    input  logic [REG_ADDR_WIDTH-1:0] dec_rd_addr_i,
    output logic                      stall_o,
    output logic                      reg_wr_en_o,
    output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_o,
    output logic [DATA_WIDTH-1:0]     reg_wr_data_o
);

    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned NUM_REGS = 1 << REG_ADDR_WIDTH;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]     data;
    } md_entry_t;

    md_entry_t               fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    logic [NUM_REGS-1:0]     pend;
    logic [NUM_REGS-1:0]     pend_next;
    md_entry_t               head;
    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;

    // Handshake and arbitration decisions; ready only looks at registered occupancy
    assign full       = (count == CNT_W'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign md_ready_o = !full && !rst;
    assign push       = md_valid_i && md_ready_o;
    assign pop        = !alu_wr_en_i && !empty;
    assign head       = fifo_mem[rd_ptr];

    assign stall_o = pend[rs1_addr_i] | pend[rs2_addr_i] | (dec_rd_en_i & pend[dec_rd_addr_i]);

    // Scoreboard update: clear on pop first so a same-cycle issue to that index wins
    always_comb begin
        pend_next = pend;
        if (pop) begin
            pend_next[head.addr] = 1'b0;
        end
        if (issue_en_i && (issue_addr_i != '0)) begin
            pend_next[issue_addr_i] = 1'b1;
        end
        pend_next[0] = 1'b0;
    end

    // Result storage carries no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= md_entry_t'({md_wr_addr_i, md_wr_data_i});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            pend   <= '0;
        end else begin
            pend <= pend_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Write port register; writes to x0 are consumed without asserting enable
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_wr_en_o   <= 1'b0;
            reg_wr_addr_o <= '0;
            reg_wr_data_o <= '0;
        end else if (alu_wr_en_i) begin
            reg_wr_en_o   <= (alu_wr_addr_i != '0);
            reg_wr_addr_o <= alu_wr_addr_i;
            reg_wr_data_o <= alu_wr_data_i;
        end else if (pop) begin
            reg_wr_en_o   <= (head.addr != '0);
            reg_wr_addr_o <= head.addr;
            reg_wr_data_o <= head.data;
        end else begin
            reg_wr_en_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios followed by random traffic, all checked
// against a queue-and-bitmap reference model of the writeback rules.
module tb_wb_arbiter;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_wr_en_i;
    logic [AW-1:0] alu_wr_addr_i;
    logic [DW-1:0] alu_wr_data_i;
    logic          md_valid_i;
    logic          md_ready_o;
    logic [AW-1:0] md_wr_addr_i;
    logic [DW-1:0] md_wr_data_i;
    logic          issue_en_i;
    logic [AW-1:0] issue_addr_i;
    logic [AW-1:0] rs1_addr_i;
    logic [AW-1:0] rs2_addr_i;
    logic          dec_rd_en_i;
    logic [AW-1:0] dec_rd_addr_i;
    logic          stall_o;
    logic          reg_wr_en_o;
    logic [AW-1:0] reg_wr_addr_o;
    logic [DW-1:0] reg_wr_data_o;

    always #5 clk = ~clk;

    wb_arbiter #(
        .DATA_WIDTH    (DW),
        .REG_ADDR_WIDTH(AW),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_wr_en_i  (alu_wr_en_i),
        .alu_wr_addr_i(alu_wr_addr_i),
        .alu_wr_data_i(alu_wr_data_i),
        .md_valid_i   (md_valid_i),
        .md_ready_o   (md_ready_o),
        .md_wr_addr_i (md_wr_addr_i),
        .md_wr_data_i (md_wr_data_i),
        .issue_en_i   (issue_en_i),
        .issue_addr_i (issue_addr_i),
        .rs1_addr_i   (rs1_addr_i),
        .rs2_addr_i   (rs2_addr_i),
        .dec_rd_en_i  (dec_rd_en_i),
        .dec_rd_addr_i(dec_rd_addr_i),
        .stall_o      (stall_o),
        .reg_wr_en_o  (reg_wr_en_o),
        .reg_wr_addr_o(reg_wr_addr_o),
        .reg_wr_data_o(reg_wr_data_o)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    // Reference model: pending results in arrival order, set of pending registers, write port
    ent_t          q[$];
    bit   [31:0]   m_pend = '0;
    bit            m_en   = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    bit            last_push;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; alu_wr_en_i = 1'b0; alu_wr_addr_i = '0; alu_wr_data_i = '0;
        md_valid_i = 1'b0; md_wr_addr_i = '0; md_wr_data_i = '0;
        issue_en_i = 1'b0; issue_addr_i = '0; rs1_addr_i = '0; rs2_addr_i = '0;
        dec_rd_en_i = 1'b0; dec_rd_addr_i = '0;
    endtask

    // One clock: check combinational outputs, advance the model, check the write port
    task automatic step(input bit chk_comb = 1'b1);
        bit   exp_ready;
        bit   exp_stall;
        ent_t h;
        #1;
        exp_ready = !rst && (q.size() < DEPTH);
        exp_stall = m_pend[rs1_addr_i] || m_pend[rs2_addr_i] || (dec_rd_en_i && m_pend[dec_rd_addr_i]);
        last_push = md_valid_i && exp_ready;
        if (chk_comb) begin
            check("md_ready", 64'(md_ready_o), 64'(exp_ready));
            check("stall", 64'(stall_o), 64'(exp_stall));
        end
        if (rst) begin
            q.delete();
            m_pend = '0;
            m_en = 1'b0; m_addr = '0; m_data = '0;
        end else begin
            if (alu_wr_en_i) begin
                m_en = (alu_wr_addr_i != 0); m_addr = alu_wr_addr_i; m_data = alu_wr_data_i;
            end else if (q.size() > 0) begin
                h = q.pop_front();
                m_en = (h.a != 0); m_addr = h.a; m_data = h.d;
                m_pend[h.a] = 1'b0;
            end else begin
                m_en = 1'b0;
            end
            if (last_push) q.push_back({md_wr_addr_i, md_wr_data_i});
            if (issue_en_i && issue_addr_i != 0) m_pend[issue_addr_i] = 1'b1;
        end
        @(posedge clk);
        #1;
        check("reg_wr_en", 64'(reg_wr_en_o), 64'(m_en));
        if (m_en || rst) begin
            check("reg_wr_addr", 64'(reg_wr_addr_o), 64'(m_addr));
            check("reg_wr_data", 64'(reg_wr_data_o), 64'(m_data));
        end
    endtask

    initial begin
        int idx;
        idle();

        // Reset for two cycles with a producer already presenting data
        rst = 1'b1; md_valid_i = 1'b1; md_wr_addr_i = 5'd3; md_wr_data_i = 32'h55;
        step(1'b0);
        step();
        check("rst_ready", 64'(md_ready_o), 64'd0);
        check("rst_en", 64'(reg_wr_en_o), 64'd0);
        idle();
        #1;
        check("ready_after_rst", 64'(md_ready_o), 64'd1);
        check("stall_after_rst", 64'(stall_o), 64'd0);

        // ALU path, one cycle latency; x0 suppressed
        alu_wr_en_i = 1'b1; alu_wr_addr_i = 5'd5; alu_wr_data_i = 32'hDEADBEEF;
        step();
        check("alu_en", 64'(reg_wr_en_o), 64'd1);
        check("alu_addr", 64'(reg_wr_addr_o), 64'd5);
        check("alu_data", 64'(reg_wr_data_o), 64'hDEADBEEF);
        alu_wr_addr_i = 5'd0;
        step();
        check("alu_x0", 64'(reg_wr_en_o), 64'd0);

        // Scoreboard stall and release when the mul/div result writes back
        idle(); issue_en_i = 1'b1; issue_addr_i = 5'd7;
        step();
        idle(); rs1_addr_i = 5'd7;
        #1;
        check("raw_stall", 64'(stall_o), 64'd1);
        md_valid_i = 1'b1; md_wr_addr_i = 5'd7; md_wr_data_i = 32'h1234;
        step();
        md_valid_i = 1'b0;
        step();
        check("md_en", 64'(reg_wr_en_o), 64'd1);
        check("md_addr", 64'(reg_wr_addr_o), 64'd7);
        check("md_data", 64'(reg_wr_data_o), 64'h1234);
        check("stall_release", 64'(stall_o), 64'd0);

        // ALU priority starves the FIFO; producer sees back-pressure, then drains in order
        idle();
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            alu_wr_en_i = 1'b1; alu_wr_addr_i = AW'(10 + i); alu_wr_data_i = $urandom;
            md_valid_i = (idx < 3); md_wr_addr_i = AW'(idx + 1); md_wr_data_i = DW'(32'hA0 + idx);
            step();
            if (last_push) idx++;
        end
        alu_wr_en_i = 1'b0;
        #1;
        check("bp_ready", 64'(md_ready_o), 64'd0);
        for (int j = 0; j < 3; j++) begin
            md_valid_i = (idx < 3); md_wr_addr_i = AW'(idx + 1); md_wr_data_i = DW'(32'hA0 + idx);
            step();
            if (last_push) idx++;
            check("drain_en", 64'(reg_wr_en_o), 64'd1);
            check("drain_order", 64'(reg_wr_addr_o), 64'(j + 1));
        end
        idle();
        step();

        // Same-cycle set and clear of pend[9]: the set wins (RAW and WAW)
        issue_en_i = 1'b1; issue_addr_i = 5'd9;
        step();
        idle(); md_valid_i = 1'b1; md_wr_addr_i = 5'd9; md_wr_data_i = 32'h99;
        step();
        idle(); issue_en_i = 1'b1; issue_addr_i = 5'd9; rs2_addr_i = 5'd9;
        step();
        idle(); rs2_addr_i = 5'd9;
        #1;
        check("set_wins_raw", 64'(stall_o), 64'd1);
        rs2_addr_i = 5'd0; dec_rd_en_i = 1'b1; dec_rd_addr_i = 5'd9;
        #1;
        check("set_wins_waw", 64'(stall_o), 64'd1);

        // Reset with two buffered results and two pending bits discards everything
        idle(); issue_en_i = 1'b1; issue_addr_i = 5'd3;
        step();
        issue_addr_i = 5'd4;
        step();
        idle(); alu_wr_en_i = 1'b1; alu_wr_addr_i = 5'd0;
        md_valid_i = 1'b1; md_wr_addr_i = 5'd3; md_wr_data_i = 32'h33;
        step();
        md_wr_addr_i = 5'd4; md_wr_data_i = 32'h44;
        step();
        idle(); rst = 1'b1;
        step();
        idle(); rs1_addr_i = 5'd3; rs2_addr_i = 5'd4; dec_rd_en_i = 1'b1; dec_rd_addr_i = 5'd9;
        #1;
        check("midrst_stall", 64'(stall_o), 64'd0);
        check("midrst_ready", 64'(md_ready_o), 64'd1);
        step();
        check("midrst_no_write", 64'(reg_wr_en_o), 64'd0);
        step();
        check("midrst_empty", 64'(reg_wr_en_o), 64'd0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst           = ($urandom_range(0, 199) == 0);
            alu_wr_en_i   = ($urandom_range(0, 99) < 45);
            alu_wr_addr_i = AW'($urandom);
            alu_wr_data_i = $urandom;
            md_valid_i    = ($urandom_range(0, 99) < 50);
            md_wr_addr_i  = AW'($urandom);
            md_wr_data_i  = $urandom;
            issue_en_i    = ($urandom_range(0, 99) < 30);
            issue_addr_i  = AW'($urandom);
            rs1_addr_i    = AW'($urandom);
            rs2_addr_i    = AW'($urandom);
            dec_rd_en_i   = $urandom_range(0, 1) == 1;
            dec_rd_addr_i = AW'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
